mesi_bus_txn_ctrl: RTL and testbench

//  Sequences one coherent bus transaction per arbiter grant: address broadcast, snoop collection, then a memory
//  or cache-to-cache data phase, then a completion pulse to the requester. Sits between the round-robin
//  bus arbiter (consumes its one-hot grant) and the shared memory port; the snooping caches hang off the bus outputs.

---
 rtl/mesi_bus_pkg.sv | 19 +
 rtl/mesi_prio_enc.sv | 14 +
 rtl/mesi_bus_txn_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_mesi_bus_txn_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesi_bus_pkg.sv
// Shared definitions for the MESI bus transaction controller: bus command codes and FSM states.
package mesi_bus_pkg;

  localparam logic [1:0] CMD_BUSRD   = 2'd0;
  localparam logic [1:0] CMD_BUSRDX  = 2'd1;
  localparam logic [1:0] CMD_BUSUPGR = 2'd2;
  localparam logic [1:0] CMD_FLUSH   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_SNOOP,
    ST_MEM,
    ST_WB,
    ST_DONE,
    ST_RELEASE
  } state_t;

endpackage

// File: rtl/mesi_prio_enc.sv
// Lowest-set-bit selector: keeps only the least significant 1 of vec as a one-hot.
module mesi_prio_enc #(
  parameter int N = 2
) (
  input  logic [N-1:0] vec,
  output logic [N-1:0] lowest
);

  localparam logic [N-1:0] ONE = N'(1);

  // Two's complement isolates the lowest set bit.
  assign lowest = vec & (~vec + ONE);

endmodule

// File: rtl/mesi_bus_txn_ctrl.sv
// One coherent bus transaction per arbiter grant: address, snoop, memory/cache data phase, completion.
// Optional memory-ack timeout enabled by defining BUS_TIMEOUT_EN.
module mesi_bus_txn_ctrl
  import mesi_bus_pkg::*;
#(
  parameter int N       = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SNP_LAT = 1,
  parameter int TMO     = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    grant,
  input  logic [2*N-1:0]  req_cmd,
  input  logic [AW*N-1:0] req_addr,
  input  logic [DW*N-1:0] req_wdata,
  output logic            bus_valid,
  output logic [1:0]      bus_cmd,
  output logic [AW-1:0]   bus_addr,
  output logic [N-1:0]    bus_src,
  input  logic [N-1:0]    snp_shared,
  input  logic [N-1:0]    snp_dirty,
  input  logic [DW*N-1:0] snp_data,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  output logic [N-1:0]    done,
  output logic [DW-1:0]   rdata,
  output logic            shared,
  output logic            err
);

  localparam int SCW = (SNP_LAT > 1) ? $clog2(SNP_LAT) : 1;
  localparam logic [N-1:0] ONE = N'(1);

  state_t          state_reg;
  logic [N-1:0]    src_reg;
  logic [1:0]      cmd_reg;
  logic [AW-1:0]   addr_reg;
  logic [DW-1:0]   wdata_reg;
  logic [DW-1:0]   data_reg;
  logic            shared_flag_reg;
  logic [SCW-1:0]  snp_cnt_reg;
`ifdef BUS_TIMEOUT_EN
  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
  logic [TW-1:0]   tmo_cnt_reg;
`endif

  logic [1:0]      cmd_g   [N];
  logic [AW-1:0]   addr_g  [N];
  logic [DW-1:0]   wdata_g [N];
  logic [DW-1:0]   odata_g [N];
  logic [1:0]      sel_cmd;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [DW-1:0]   owner_data;
  logic            grant_ok;
  logic [N-1:0]    mask_shared;
  logic [N-1:0]    mask_dirty;
  logic [N-1:0]    owner_oh;
  logic            sh;
  logic            dty;

  // The requester never snoops its own transaction.
  assign mask_shared = snp_shared & ~src_reg;
  assign mask_dirty  = snp_dirty & ~src_reg;
  assign sh          = |mask_shared;
  assign dty         = |mask_dirty;
  assign grant_ok    = (|grant) && ((grant & (grant - ONE)) == '0);

  mesi_prio_enc #(.N(N)) u_owner (
    .vec    (mask_dirty),
    .lowest (owner_oh)
  );

  for (genvar gi = 0; gi < N; gi++) begin : g_cache
    assign cmd_g[gi]   = grant[gi] ? req_cmd[2*gi +: 2] : 2'b00;
    assign addr_g[gi]  = grant[gi] ? req_addr[AW*gi +: AW] : '0;
    assign wdata_g[gi] = grant[gi] ? req_wdata[DW*gi +: DW] : '0;
    assign odata_g[gi] = owner_oh[gi] ? snp_data[DW*gi +: DW] : '0;
  end

  always_comb begin
    sel_cmd    = '0;
    sel_addr   = '0;
    sel_wdata  = '0;
    owner_data = '0;
    for (int i = 0; i < N; i++) begin
      sel_cmd    = sel_cmd | cmd_g[i];
      sel_addr   = sel_addr | addr_g[i];
      sel_wdata  = sel_wdata | wdata_g[i];
      owner_data = owner_data | odata_g[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      src_reg         <= '0;
      cmd_reg         <= CMD_BUSRD;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      data_reg        <= '0;
      shared_flag_reg <= 1'b0;
      snp_cnt_reg     <= '0;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt_reg     <= '0;
`endif
      bus_valid       <= 1'b0;
      bus_cmd         <= '0;
      bus_addr        <= '0;
      bus_src         <= '0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      done            <= '0;
      rdata           <= '0;
      shared          <= 1'b0;
      err             <= 1'b0;
    end else begin
      bus_valid <= 1'b0;
      done      <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (grant_ok) begin
            src_reg   <= grant;
            cmd_reg   <= sel_cmd;
            addr_reg  <= sel_addr;
            wdata_reg <= sel_wdata;
            bus_valid <= 1'b1;
            bus_cmd   <= sel_cmd;
            bus_addr  <= sel_addr;
            bus_src   <= grant;
            state_reg <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          snp_cnt_reg <= '0;
          state_reg   <= ST_SNOOP;
        end
        ST_SNOOP: begin
          if (snp_cnt_reg == SCW'(SNP_LAT - 1)) begin
            bus_cmd         <= '0;
            bus_addr        <= '0;
            bus_src         <= '0;
            shared_flag_reg <= (cmd_reg == CMD_BUSRD) && (sh || dty);
            data_reg        <= '0;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt_reg     <= '0;
`endif
            if (cmd_reg == CMD_BUSUPGR) begin
              done      <= src_reg;
              rdata     <= '0;
              shared    <= 1'b0;
              err       <= 1'b0;
              state_reg <= ST_DONE;
            end else if (cmd_reg == CMD_FLUSH) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= addr_reg;
              mem_wdata <= wdata_reg;
              state_reg <= ST_MEM;
            end else if (dty) begin
              data_reg <= owner_data;
              // A dirty owner on BusRd must also refresh memory before the line goes shared.
              if (cmd_reg == CMD_BUSRD) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= addr_reg;
                mem_wdata <= owner_data;
                state_reg <= ST_WB;
              end else begin
                done      <= src_reg;
                rdata     <= owner_data;
                shared    <= 1'b0;
                err       <= 1'b0;
                state_reg <= ST_DONE;
              end
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= addr_reg;
              mem_wdata <= '0;
              state_reg <= ST_MEM;
            end
          end else begin
            snp_cnt_reg <= snp_cnt_reg + SCW'(1);
          end
        end
        ST_MEM, ST_WB: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= src_reg;
            rdata     <= mem_we ? data_reg : mem_rdata;
            shared    <= shared_flag_reg;
            err       <= 1'b0;
            state_reg <= ST_DONE;
          end
`ifdef BUS_TIMEOUT_EN
          else if (tmo_cnt_reg == TW'(TMO - 1)) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= src_reg;
            rdata     <= '0;
            shared    <= 1'b0;
            err       <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
          end
`endif
        end
        ST_DONE: begin
          rdata     <= '0;
          shared    <= 1'b0;
          err       <= 1'b0;
          state_reg <= ST_RELEASE;
        end
        ST_RELEASE: begin
          // Wait for the arbiter to withdraw this grant so it is not served twice.
          if ((grant & src_reg) == '0) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesi_bus_txn_ctrl.sv
// Self-checking bench for mesi_bus_txn_ctrl: vector table with scoreboard queue plus corner-case sequences.
module tb_mesi_bus_txn_ctrl;
  import mesi_bus_pkg::*;

  localparam int N       = 3;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int SNP_LAT = 1;
  localparam int TMO     = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    grant;
  logic [2*N-1:0]  req_cmd;
  logic [AW*N-1:0] req_addr;
  logic [DW*N-1:0] req_wdata;
  logic            bus_valid;
  logic [1:0]      bus_cmd;
  logic [AW-1:0]   bus_addr;
  logic [N-1:0]    bus_src;
  logic [N-1:0]    snp_shared;
  logic [N-1:0]    snp_dirty;
  logic [DW*N-1:0] snp_data;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_ack = 1'b0;
  logic [DW-1:0]   mem_rdata;
  logic [N-1:0]    done;
  logic [DW-1:0]   rdata;
  logic            shared;
  logic            err;

  mesi_bus_txn_ctrl #(
    .N(N), .AW(AW), .DW(DW), .SNP_LAT(SNP_LAT), .TMO(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .grant(grant), .req_cmd(req_cmd), .req_addr(req_addr),
    .req_wdata(req_wdata), .bus_valid(bus_valid), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
    .bus_src(bus_src), .snp_shared(snp_shared), .snp_dirty(snp_dirty), .snp_data(snp_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .done(done), .rdata(rdata), .shared(shared),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   src;
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [N-1:0]  shd;
    logic [N-1:0]  dty;
    logic [DW*N-1:0] sdata;
    logic [DW-1:0] mrdata;
    int            ack_dly;
    bit            exp_mem;
    bit            exp_we;
    logic [AW-1:0] exp_maddr;
    logic [DW-1:0] exp_mwdata;
    logic [DW-1:0] exp_rdata;
    bit            exp_shared;
    bit            exp_err;
    int            exp_lat;
  } vec_t;

  vec_t tbl [10];
  vec_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  bit   ack_en = 1'b1;
  int   ack_dly = 0;
  int   wait_cnt = 0;

  // Memory model: ack pulse after ack_dly extra cycles of mem_req.
  always @(negedge clk) begin
    if (mem_ack || !ack_en || !mem_req) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt >= ack_dly) begin
      mem_ack = 1'b1;
    end else begin
      wait_cnt++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic run_txn(input vec_t v, input bit hold, output int mem_cycles);
    vec_t          e;
    int            cyc;
    bit            seen;
    int            bv_cnt;
    logic [1:0]    b_cmd;
    logic [AW-1:0] b_addr;
    logic [N-1:0]  b_src;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    bit            m_unstable;
    logic [N-1:0]  d_done;
    logic [DW-1:0] d_rdata;
    logic          d_sh;
    logic          d_err;
    logic [N-1:0]  g;
    logic [N-1:0]  edone;
    g = '0;
    g[v.src] = 1'b1;
    req_cmd   = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_cmd[2*v.src +: 2]    = v.cmd;
    req_addr[AW*v.src +: AW] = v.addr;
    req_wdata[DW*v.src +: DW] = v.wdata;
    snp_shared = v.shd;
    snp_dirty  = v.dty;
    snp_data   = v.sdata;
    mem_rdata  = v.mrdata;
    ack_dly    = v.ack_dly;
    exp_q.push_back(v);
    grant = g;
    cyc = 0; seen = 1'b0; bv_cnt = 0; mem_cycles = 0; m_unstable = 1'b0;
    b_cmd = '0; b_addr = '0; b_src = '0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    d_done = '0; d_rdata = '0; d_sh = 1'b0; d_err = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus_valid) begin
        bv_cnt++;
        b_cmd = bus_cmd; b_addr = bus_addr; b_src = bus_src;
      end
      if (mem_req) begin
        if (mem_cycles == 0) begin
          m_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata;
        end else if (mem_we !== m_we || mem_addr !== m_addr || mem_wdata !== m_wdata) begin
          m_unstable = 1'b1;
        end
        mem_cycles++;
      end
      if (done != '0) begin
        seen = 1'b1;
        d_done = done; d_rdata = rdata; d_sh = shared; d_err = err;
      end
    end
    if (!hold) grant = '0;
    e = exp_q.pop_front();
    edone = '0;
    edone[e.src] = 1'b1;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=none required=%b", edone);
    end else begin
      $display("txn src=%0d cmd=%0d addr=%h done=%b rdata=%h shared=%b err=%b lat=%0d mem_cycles=%0d",
               e.src, e.cmd, e.addr, d_done, d_rdata, d_sh, d_err, cyc, mem_cycles);
      chk("bus_strobes", bv_cnt, 1);
      chk("bus_cmd", b_cmd, e.cmd);
      chk("bus_addr", b_addr, e.addr);
      chk("bus_src", b_src, edone);
      chk("done", d_done, edone);
      chk("rdata", d_rdata, e.exp_rdata);
      chk("shared", d_sh, e.exp_shared);
      chk("err", d_err, e.exp_err);
      chk("latency", cyc, e.exp_lat);
      chk("mem_used", mem_cycles != 0, e.exp_mem);
      if (e.exp_mem) begin
        chk("mem_we", m_we, e.exp_we);
        chk("mem_addr", m_addr, e.exp_maddr);
        if (e.exp_we) chk("mem_wdata", m_wdata, e.exp_mwdata);
        chk("mem_stable", m_unstable, 1'b0);
      end
    end
    if (!hold) repeat (2) @(negedge clk);
  endtask

  initial begin
    int   mc;
    int   cnt;
    bit   found;
    vec_t tv;
    rst_n = 1'b0;
    grant = '0; req_cmd = '0; req_addr = '0; req_wdata = '0;
    snp_shared = '0; snp_dirty = '0; snp_data = '0; mem_rdata = '0;

    //        src cmd          addr       wdata     shd     dty     sdata {c2,c1,c0}                    mrdata    dly mem we maddr      mwdata    rdata     sh err lat
    tbl[0] = '{0, CMD_BUSRD,   32'h100, 32'h0,  3'b000, 3'b000, {32'h0, 32'h0, 32'h0},          32'hAA,   0, 1, 0, 32'h100, 32'h0,  32'hAA,   0, 0, 4};
    tbl[1] = '{1, CMD_BUSRD,   32'h200, 32'h0,  3'b001, 3'b001, {32'h0, 32'h0, 32'h55},         32'h0,    0, 1, 1, 32'h200, 32'h55, 32'h55,   1, 0, 4};
    tbl[2] = '{0, CMD_BUSUPGR, 32'h300, 32'h0,  3'b010, 3'b000, {32'h0, 32'h0, 32'h0},          32'h0,    0, 0, 0, 32'h0,   32'h0,  32'h0,    0, 0, 3};
    tbl[3] = '{0, CMD_BUSRDX,  32'h400, 32'h0,  3'b110, 3'b110, {32'h88, 32'h77, 32'h0},        32'h0,    0, 0, 0, 32'h0,   32'h0,  32'h77,   0, 0, 3};
    tbl[4] = '{1, CMD_FLUSH,   32'h500, 32'h99, 3'b101, 3'b000, {32'h0, 32'h0, 32'h0},          32'h0,    0, 1, 1, 32'h500, 32'h99, 32'h0,    0, 0, 4};
    tbl[5] = '{0, CMD_BUSRD,   32'h600, 32'h0,  3'b100, 3'b000, {32'h0, 32'h0, 32'h0},          32'h1234, 2, 1, 0, 32'h600, 32'h0,  32'h1234, 1, 0, 6};
    tbl[6] = '{1, CMD_BUSRD,   32'h700, 32'h0,  3'b010, 3'b010, {32'h0, 32'hBAD, 32'h0},        32'hBEEF, 0, 1, 0, 32'h700, 32'h0,  32'hBEEF, 0, 0, 4};
    tbl[7] = '{2, CMD_BUSRD,   32'h800, 32'h0,  3'b011, 3'b011, {32'h0, 32'h22, 32'h11},        32'h0,    1, 1, 1, 32'h800, 32'h11, 32'h11,   1, 0, 5};
    tbl[8] = '{2, CMD_BUSRDX,  32'h900, 32'h0,  3'b001, 3'b000, {32'h0, 32'h0, 32'h0},          32'hCAFE, 0, 1, 0, 32'h900, 32'h0,  32'hCAFE, 0, 0, 4};
    tbl[9] = '{1, CMD_BUSRD,   32'hA00, 32'h0,  3'b000, 3'b100, {32'h3C, 32'h0, 32'hFF},        32'h0,    0, 1, 1, 32'hA00, 32'h3C, 32'h3C,   1, 0, 4};

    repeat (3) @(negedge clk);
    chk("rst_ctrl", {bus_valid, bus_cmd, bus_src, mem_req, mem_we, done, shared, err}, 0);
    chk("rst_addr", {bus_addr, mem_addr}, 0);
    chk("rst_data", {mem_wdata, rdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_txn(tbl[i], 1'b0, mc);

    // Held grant must not start a second transaction.
    run_txn(tbl[0], 1'b1, mc);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus_valid || mem_req || done != '0) cnt++;
    end
    chk("held_grant_idle", cnt, 0);
    grant = '0;
    repeat (2) @(negedge clk);
    run_txn(tbl[1], 1'b0, mc);

    // Multi-bit grant is ignored.
    grant = 3'b011;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_valid) cnt++;
    end
    chk("multi_grant_ignored", cnt, 0);
    grant = '0;
    @(negedge clk);

    // Asynchronous reset in the middle of a memory phase.
    ack_en = 1'b0;
    req_cmd = '0; req_addr = '0;
    req_cmd[1:0] = CMD_BUSRD;
    req_addr[AW-1:0] = 32'h100;
    snp_shared = '0; snp_dirty = '0;
    grant = 3'b001;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (mem_req) found = 1'b1;
    end
    chk("rst_seq_mem_req_seen", found, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem", {mem_req, bus_valid, done, err, shared}, 0);
    $display("txn async reset during memory phase mem_req=%b bus_valid=%b done=%b", mem_req, bus_valid, done);
    grant = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    @(negedge clk);
    run_txn(tbl[1], 1'b0, mc);

`ifdef BUS_TIMEOUT_EN
    ack_en = 1'b0;
    tv = '{0, CMD_BUSRD, 32'hB00, 32'h0, 3'b000, 3'b000, {32'h0, 32'h0, 32'h0},
           32'hDEAD, 0, 1, 0, 32'hB00, 32'h0, 32'h0, 0, 1, 3 + TMO};
    run_txn(tv, 1'b0, mc);
    chk("tmo_mem_cycles", mc, TMO);
    ack_en = 1'b1;
`else
    tv = tbl[8];
    run_txn(tv, 1'b0, mc);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
